bist_misr_analyzer: RTL
=======================

Name: bist_misr_analyzer

Overview:
Downstream response-compaction stage for the BIST CUT path. It samples the CUT outputs (fz_L, lclk, read_a, test_out) on every valid test cycle and folds them into a multiple-input signature register (MISR). After a programmed number of samples it compares the signature against a golden value and drives bist_end and pass_nfail at the top level.

Parameters:
MISR_W, 16, signature register width; must be >= 9.
POLY, 16'h1021, feedback polynomial; XORed into the shifted register when the MSB shifted out is 1.
SEED, 16'hFFFF, MISR value loaded at run start.
N_SAMPLES, 30, number of valid response samples per run; legal range 1..2^CNT_W-1.
CNT_W, 8, sample counter width.
GOLDEN, 16'h0000, expected final signature; set per CUT at integration.

Ports:
clock  input  1  system clock; all state changes on posedge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
bist_start  input  1  run request; rising edge detected internally.
resp_valid  input  1  current response word is valid and is compacted this cycle.
fz_L  input  1  CUT output; response bit 8.
lclk  input  1  CUT output; response bit 7.
read_a  input  5  CUT output; response bits 6:2.
test_out  input  2  CUT output; response bits 1:0.
busy  output  1  high while in COMPACT or COMPARE.
bist_end  output  1  run complete; sticky until the next run starts or reset.
pass_nfail  output  1  1 = signature matched GOLDEN; valid only while bist_end=1.

Behaviour:
- Response word R[8:0] = {fz_L, lclk, read_a, test_out}, zero-extended to MISR_W.
- MISR update: next = {misr[MISR_W-2:0],1'b0} ^ (misr[MISR_W-1] ? POLY : 0) ^ R_ext.
- Start edge: start_re = bist_start & ~start_q, where start_q is registered bist_start. Reset sets start_q to 0.
- Reset (asynchronous, at any time including mid-run): state=IDLE, misr=SEED, cnt=0, start_q=0, busy=0, bist_end=0, pass_nfail=0.
- FSM states are IDLE, COMPACT, COMPARE and DONE.
- IDLE:
  - On start_re: misr<=SEED, cnt<=0, bist_end<=0, pass_nfail<=0, go to COMPACT.
  - resp_valid is ignored.
- COMPACT:
  - On each edge with resp_valid=1: MISR is updated and cnt increments.
  - When cnt==N_SAMPLES-1 and resp_valid=1, the update is applied and the FSM goes to COMPARE.
  - resp_valid=0 holds misr and cnt; gaps of any length are allowed.
  - start_re is ignored; no restart mid-run.
- COMPARE: one cycle. pass_nfail<=(misr==GOLDEN), bist_end<=1, go to DONE.
- Latency: with the last sample captured at edge E, bist_end and pass_nfail are registered at edge E+1.
- DONE:
  - Holds bist_end=1 and pass_nfail.
  - resp_valid is ignored.
  - start_re behaves as in IDLE: bist_end and pass_nfail clear at the same edge and the FSM enters COMPACT.
- busy = (state==COMPACT)|(state==COMPARE), decoded from registered state.
- pass_nfail is 0 whenever bist_end=0.
- If bist_start is held high continuously, only one run occurs; it must drop and rise again to restart.
- cnt never wraps; it is cleared only at run start or reset.

Optional Feature:
Macro BIST_SIG_OUT_EN.
- Defined: adds output port signature [MISR_W-1:0], driven directly from the MISR register. Resets to SEED. Valid for debug and golden-value extraction at all times.
- Undefined: the port does not exist, and behaviour on all other ports is identical.

Test Plan:
1. Reset low mid-COMPACT (after 5 valid samples) -> busy=0, bist_end=0, pass_nfail=0 immediately (asynchronous). The next start_re begins a fresh run from SEED.
2. Single-bit sample: SEED=0, N_SAMPLES=1, R=9'h001. Debug signature=16'h0001; with GOLDEN=16'h0001 -> bist_end=1, pass_nfail=1 one edge after the sample.
3. Shift check: SEED=0, N_SAMPLES=2, samples 9'h001 then 9'h000 -> signature 16'h0002. Feedback check: SEED=16'h8000, N_SAMPLES=1, R=0 -> signature 16'h1021.
4. Default params, 30 all-zero samples with resp_valid gaps of 0-3 cycles, GOLDEN set to the precomputed SEED-driven value -> pass_nfail=1. Flip test_out[0] in sample 17 -> pass_nfail=0.
5. start_re pulsed during COMPACT -> ignored, cnt continues. start_re in DONE -> bist_end and pass_nfail clear at that edge, busy=1.
6. bist_start held high through the whole run and after DONE -> exactly one run; bist_end stays 1 until bist_start toggles 0 then 1.

Source files
------------

// File: rtl/bist_misr_analyzer.sv
// bist_misr_analyzer
//   Compacts the CUT response word {fz_L, lclk, read_a, test_out} into a MISR
//   over N_SAMPLES valid cycles. It then compares the signature against GOLDEN
//   and reports the result on bist_end / pass_nfail.
//   Optional: define BIST_SIG_OUT_EN to expose the raw MISR on port "signature".
module bist_misr_analyzer #(
   parameter int unsigned        MISR_W    = 16,
   parameter logic [MISR_W-1:0]  POLY      = 16'h1021,
   parameter logic [MISR_W-1:0]  SEED      = 16'hFFFF,
   parameter int unsigned        N_SAMPLES = 30,
   parameter int unsigned        CNT_W     = 8,
   parameter logic [MISR_W-1:0]  GOLDEN    = 16'h0000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              bist_start,
   input  logic              resp_valid,
   input  logic              fz_L,
   input  logic              lclk,
   input  logic [4:0]        read_a,
   input  logic [1:0]        test_out,
   output logic              busy,
   output logic              bist_end,
   output logic              pass_nfail
`ifdef BIST_SIG_OUT_EN
   ,
   output logic [MISR_W-1:0] signature
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPACT,
      S_COMPARE,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

   state_t              state_q;
   state_t              state_d;
   logic [MISR_W-1:0]   misr_q;
   logic [MISR_W-1:0]   misr_next;
   logic [MISR_W-1:0]   resp_ext;
   logic [8:0]          resp_word;
   logic [CNT_W-1:0]    cnt_q;
   logic                start_q;
   logic                start_re;
   logic                run_start;
   logic                sample_en;
   logic                cmp_en;
   logic                bist_end_q;
   logic                pass_q;

   assign resp_word = {fz_L, lclk, read_a, test_out};
   assign resp_ext  = MISR_W'(resp_word);
   assign start_re  = bist_start & ~start_q;

   // MISR next value: shift left, fold in polynomial on MSB carry-out, XOR response
   always_comb begin
      misr_next = {misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? POLY : '0) ^ resp_ext;
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state and datapath control strobes
   always_comb begin
      state_d   = state_q;
      run_start = 1'b0;
      sample_en = 1'b0;
      cmp_en    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_re) begin
               run_start = 1'b1;
               state_d   = S_COMPACT;
            end
         end
         S_COMPACT: begin
            if (resp_valid) begin
               sample_en = 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = S_COMPARE;
               end
            end
         end
         S_COMPARE: begin
            cmp_en  = 1'b1;
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Signature, sample counter, start-edge history and registered result flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         misr_q     <= SEED;
         cnt_q      <= '0;
         start_q    <= 1'b0;
         bist_end_q <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         start_q <= bist_start;
         if (run_start) begin
            misr_q     <= SEED;
            cnt_q      <= '0;
            bist_end_q <= 1'b0;
            pass_q     <= 1'b0;
         end else if (sample_en) begin
            misr_q <= misr_next;
            cnt_q  <= cnt_q + 1'b1;
         end
         if (cmp_en) begin
            bist_end_q <= 1'b1;
            pass_q     <= (misr_q == GOLDEN);
         end
      end
   end

   assign busy       = (state_q == S_COMPACT) | (state_q == S_COMPARE);
   assign bist_end   = bist_end_q;
   assign pass_nfail = pass_q;

`ifdef BIST_SIG_OUT_EN
   assign signature = misr_q;
`endif

endmodule
